// File: rtl/wb_pkg.sv
// Shared types for the write-back port arbiter: entry layout, x0 index and grant encoding.
package wb_pkg;

    localparam int WB_XLEN = 64;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_LD,
        GNT_ALU
    } wb_gnt_e;

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO with a combinational head view and an occupancy count.
module wb_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 69
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Depth is a power of two, so pointer overflow is the wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between load and ALU write-back,
// buffering ALU results and forcing the ALU through after STARVE_LIMIT load wins.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [4:0]                      alu_reg,
    input  logic [XLEN-1:0]                 alu_data,
    input  logic                            ld_valid,
    output logic                            ld_ready,
    input  logic [4:0]                      ld_reg,
    input  logic [XLEN-1:0]                 ld_data,
    output logic                            write_enable,
    output logic [4:0]                      write_reg,
    output logic [XLEN-1:0]                 write_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] alu_pending
);

    localparam int PEND_W = $clog2(FIFO_DEPTH + 1);
    localparam int SW     = $clog2(STARVE_LIMIT + 1);
    localparam int EW     = 5 + XLEN;

    logic [EW-1:0]     fifo_head;
    logic [PEND_W-1:0] fifo_count;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    logic              alu_in_live;
    logic              alu_cand_valid;
    logic [4:0]        cand_reg;
    logic [XLEN-1:0]   cand_data;
    logic              force_alu;
    wb_gnt_e           gnt;

    logic              write_enable_q, write_enable_d;
    logic [4:0]        write_reg_q, write_reg_d;
    logic [XLEN-1:0]   write_data_q, write_data_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;

    wb_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_alu_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({alu_reg, alu_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    // x0 entries complete their handshake but never become a candidate.
    always_comb begin
        fifo_empty     = (fifo_count == '0);
        alu_ready      = (fifo_count < PEND_W'(FIFO_DEPTH));
        alu_in_live    = alu_valid && alu_ready && (alu_reg != REG_ZERO);
        alu_cand_valid = !fifo_empty || alu_in_live;
        cand_reg       = fifo_empty ? alu_reg  : fifo_head[EW-1 -: 5];
        cand_data      = fifo_empty ? alu_data : fifo_head[XLEN-1:0];
        force_alu      = (starve_cnt_q == SW'(STARVE_LIMIT)) && alu_cand_valid;
        ld_ready       = !force_alu;

        if (force_alu) begin
            gnt = GNT_ALU;
        end else if (ld_valid && (ld_reg != REG_ZERO)) begin
            gnt = GNT_LD;
        end else if (alu_cand_valid) begin
            gnt = GNT_ALU;
        end else begin
            gnt = GNT_NONE;
        end

        // Bypass only when the FIFO is empty, so a buffered head always goes first.
        fifo_push = alu_in_live && !((gnt == GNT_ALU) && fifo_empty);
        fifo_pop  = (gnt == GNT_ALU) && !fifo_empty;

        write_enable_d = 1'b0;
        write_reg_d    = write_reg_q;
        write_data_d   = write_data_q;
        case (gnt)
            GNT_LD: begin
                write_enable_d = 1'b1;
                write_reg_d    = ld_reg;
                write_data_d   = ld_data;
            end
            GNT_ALU: begin
                write_enable_d = 1'b1;
                write_reg_d    = cand_reg;
                write_data_d   = cand_data;
            end
            default: ;
        endcase

        starve_cnt_d = starve_cnt_q;
        if ((gnt == GNT_ALU) || !alu_cand_valid) begin
            starve_cnt_d = '0;
        end else if ((gnt == GNT_LD) && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_enable_q <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
            starve_cnt_q   <= '0;
        end else begin
            write_enable_q <= write_enable_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
            starve_cnt_q   <= starve_cnt_d;
        end
    end

    assign write_enable = write_enable_q;
    assign write_reg    = write_reg_q;
    assign write_data   = write_data_q;
    assign alu_pending  = fifo_count;

endmodule
